// File: rtl/bip_pkg.sv
// bip_pkg: opcode, selector, ALU-op and state encodings plus the control-word type shared by the BIP control unit.
package bip_pkg;
    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;
    localparam logic [1:0] SELA_MEM = 2'b00;
    localparam logic [1:0] SELA_EXT = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;
    localparam logic SELB_MEM = 1'b0;
    localparam logic SELB_EXT = 1'b1;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;
endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: purely combinational opcode to control-word decode; unknown opcodes decode as NOP.
module bip_decoder
    import bip_pkg::*;
#(
    parameter int NBITS_C = 5
)(
    input  logic [NBITS_C-1:0] i_opcode,
    output ctrl_t              o_ctrl
);
    always_comb begin
        o_ctrl = '{sel_a: SELA_MEM, sel_b: SELB_MEM, op: OP_ADD, wr_acc: 1'b0, wr_ram: 1'b0, rd_ram: 1'b0};
        case (i_opcode)
            OPC_STO: o_ctrl.wr_ram = 1'b1;
            OPC_LD: begin
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.rd_ram = 1'b1;
            end
            OPC_LDI: begin
                o_ctrl.sel_a  = SELA_EXT;
                o_ctrl.wr_acc = 1'b1;
            end
            OPC_ADD: begin
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.rd_ram = 1'b1;
            end
            OPC_ADDI: begin
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.sel_b  = SELB_EXT;
                o_ctrl.wr_acc = 1'b1;
            end
            OPC_SUB: begin
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.op     = OP_SUB;
                o_ctrl.wr_acc = 1'b1;
                o_ctrl.rd_ram = 1'b1;
            end
            OPC_SUBI: begin
                o_ctrl.sel_a  = SELA_ALU;
                o_ctrl.sel_b  = SELB_EXT;
                o_ctrl.op     = OP_SUB;
                o_ctrl.wr_acc = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/bip_control.sv
// bip_control: PC, IDLE/RUN/HALT state machine and gated decode for the accumulator datapath; BIP_CYCLE_COUNT_EN adds o_CycleCount.
module bip_control
    import bip_pkg::*;
#(
    parameter int NBITS_O = 11,
    parameter int NBITS_C = 5,
    parameter int NBITS_D = 16
)(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NBITS_D-1:0] i_Instruction,
    output logic [NBITS_O-1:0] o_PC,
    output logic [NBITS_O-1:0] o_Operand,
    output logic [1:0]         o_SelA,
    output logic               o_SelB,
    output logic               o_WrAcc,
    output logic               o_Op,
    output logic               o_WrRam,
    output logic               o_RdRam,
    output logic               o_Running,
    output logic               o_Halted
`ifdef BIP_CYCLE_COUNT_EN
    ,output logic [31:0]       o_CycleCount
`endif
);
    state_t             r_state, w_next_state;
    logic [NBITS_O-1:0] r_pc, w_next_pc;
    ctrl_t              w_dec, w_ctrl;
    logic               w_run, w_hlt;

    bip_decoder #(.NBITS_C(NBITS_C)) u_dec (
        .i_opcode (i_Instruction[NBITS_D-1:NBITS_O]),
        .o_ctrl   (w_dec)
    );

    assign w_hlt  = i_Instruction[NBITS_D-1:NBITS_O] == OPC_HLT;
    // Reset kills strobes combinationally so nothing commits on the reset edge.
    assign w_run  = r_state == ST_RUN && !i_reset;
    assign w_ctrl = w_run ? w_dec : '0;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            ST_IDLE: w_next_state = i_start ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                w_next_state = w_hlt ? ST_HALT : ST_RUN;
                w_next_pc    = w_hlt ? r_pc : r_pc + NBITS_O'(1);
            end
            ST_HALT: begin
                w_next_state = i_start ? ST_RUN : ST_HALT;
                w_next_pc    = i_start ? '0 : r_pc;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    assign o_PC      = r_pc;
    assign o_Operand = i_Instruction[NBITS_O-1:0];
    assign o_SelA    = w_ctrl.sel_a;
    assign o_SelB    = w_ctrl.sel_b;
    assign o_Op      = w_ctrl.op;
    assign o_WrAcc   = w_ctrl.wr_acc;
    assign o_WrRam   = w_ctrl.wr_ram;
    assign o_RdRam   = w_ctrl.rd_ram;
    assign o_Running = w_run;
    assign o_Halted  = r_state == ST_HALT && !i_reset;

`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] r_cycles;

    always_ff @(posedge i_clock) begin
        if (i_reset || (r_state == ST_HALT && i_start))
            r_cycles <= '0;
        else if (r_state == ST_RUN && r_cycles != '1)
            r_cycles <= r_cycles + 32'd1;
    end

    assign o_CycleCount = r_cycles;
`endif
endmodule
